// File: rtl/approx_err_pkg.sv
// rtl/approx_err_pkg.sv - shared state encoding and default widths for the error monitor
package approx_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 17;
    localparam int DEF_ACC_W = 26;

endpackage

// File: rtl/err_dist_unit.sv
// rtl/err_dist_unit.sv - combinational exact-sum recompute and error distance for one sample
module err_dist_unit
    import approx_err_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    cin,
    input  logic [WIDTH:0]          s_approx,
    output logic signed [WIDTH+1:0] ed,
    output logic [WIDTH:0]          abs_ed,
    output logic                    mismatch
);

    logic [WIDTH:0] exact;

    // Exact sum keeps the carry-out, so it never truncates.
    assign exact    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign ed       = $signed({1'b0, s_approx}) - $signed({1'b0, exact});
    assign abs_ed   = (s_approx >= exact) ? (s_approx - exact) : (exact - s_approx);
    assign mismatch = (s_approx != exact);

endmodule

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - accumulates error metrics of an approximate adder over a run
module approx_adder_error_monitor
    import approx_err_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH:0]   s_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [ACC_W:0]   sum_sgn_err,
    output logic [WIDTH:0]   max_abs_err,
    output logic [WIDTH-1:0] max_err_a,
    output logic [WIDTH-1:0] max_err_b
);

    state_t state, state_next;

    logic             start_ok;
    logic             xfer;
    logic             last_xfer;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] n_lat;

    logic             s1_valid, s2_valid;
    logic [WIDTH-1:0] s1_a, s1_b, s2_a, s2_b;
    logic             s1_cin, s2_cin;
    logic [WIDTH:0]   s1_s, s2_s;

    logic signed [WIDTH+1:0] s2_ed;
    logic [WIDTH:0]          s2_abs;
    logic                    s2_mismatch;
    logic [ACC_W:0]          abs_sum_next;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_ready  = (state == ST_RUN);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (sample_cnt == n_lat - CNT_W'(1));
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_next = (n_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_xfer) begin
                    state_next = ST_DRAIN;
                end
            end
            // No transfers happen in DRAIN, so once S1 is empty this edge also empties S2.
            ST_DRAIN: begin
                if (!s1_valid) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_s     <= '0;
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_cin   <= 1'b0;
            s2_s     <= '0;
        end else if (start_ok) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_cin <= cin;
                s1_s   <= s_approx;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a   <= s1_a;
                s2_b   <= s1_b;
                s2_cin <= s1_cin;
                s2_s   <= s1_s;
            end
        end
    end

    err_dist_unit #(
        .WIDTH(WIDTH)
    ) u_dist (
        .a        (s2_a),
        .b        (s2_b),
        .cin      (s2_cin),
        .s_approx (s2_s),
        .ed       (s2_ed),
        .abs_ed   (s2_abs),
        .mismatch (s2_mismatch)
    );

    // One extra headroom bit exposes the carry that triggers saturation.
    assign abs_sum_next = {1'b0, sum_abs_err} + {{(ACC_W-WIDTH){1'b0}}, s2_abs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= '0;
            n_lat       <= '0;
            err_count   <= '0;
            sum_abs_err <= '0;
            sum_sgn_err <= '0;
            max_abs_err <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
        end else if (start_ok) begin
            sample_cnt  <= '0;
            n_lat       <= n_samples;
            err_count   <= '0;
            sum_abs_err <= '0;
            sum_sgn_err <= '0;
            max_abs_err <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
        end else begin
            if (xfer) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if (s2_valid) begin
                if (s2_mismatch) begin
                    err_count <= err_count + CNT_W'(1);
                end
                sum_abs_err <= abs_sum_next[ACC_W] ? '1 : abs_sum_next[ACC_W-1:0];
                sum_sgn_err <= sum_sgn_err + {{(ACC_W-WIDTH-1){s2_ed[WIDTH+1]}}, s2_ed};
                // Strict compare: ties keep the operands of the first occurrence.
                if (s2_abs > max_abs_err) begin
                    max_abs_err <= s2_abs;
                    max_err_a   <= s2_a;
                    max_err_b   <= s2_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb/tb_approx_adder_error_monitor.sv - self-checking bench for approx_adder_error_monitor
module tb_approx_adder_error_monitor;
    import approx_err_pkg::*;

    localparam int W   = 8;
    localparam int CW  = 17;
    localparam int AW  = 26;
    localparam int AWS = 10;
    localparam longint SAT_MAX = (longint'(1) << AW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, in_valid, cin;
    logic [CW-1:0] n_samples;
    logic [W-1:0]  a, b;
    logic [W:0]    s_approx;

    logic          in_ready, busy, done;
    logic [CW-1:0] err_count;
    logic [AW-1:0] sum_abs_err;
    logic [AW:0]   sum_sgn_err;
    logic [W:0]    max_abs_err;
    logic [W-1:0]  max_err_a, max_err_b;

    logic           sat_in_ready, sat_busy, sat_done;
    logic [CW-1:0]  sat_err_count;
    logic [AWS-1:0] sat_sum_abs_err;
    logic [AWS:0]   sat_sum_sgn_err;
    logic [W:0]     sat_max_abs_err;
    logic [W-1:0]   sat_max_err_a, sat_max_err_b;

    approx_adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .s_approx(s_approx), .busy(busy), .done(done), .err_count(err_count),
        .sum_abs_err(sum_abs_err), .sum_sgn_err(sum_sgn_err),
        .max_abs_err(max_abs_err), .max_err_a(max_err_a), .max_err_b(max_err_b)
    );

    approx_adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(sat_in_ready), .a(a), .b(b), .cin(cin),
        .s_approx(s_approx), .busy(sat_busy), .done(sat_done), .err_count(sat_err_count),
        .sum_abs_err(sat_sum_abs_err), .sum_sgn_err(sat_sum_sgn_err),
        .max_abs_err(sat_max_abs_err), .max_err_a(sat_max_err_a), .max_err_b(sat_max_err_b)
    );

    typedef struct {
        longint err;
        longint abs_sum;
        longint sgn;
        longint mx;
        longint ma;
        longint mb;
    } metrics_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   s;
        metrics_t     exp_m;
    } vec_t;

    int tests = 0;
    int fails = 0;

    metrics_t     exp_q[$];
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];
    logic [W:0]   qs[$];
    vec_t         tbl[7];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_metrics(input string tag, input metrics_t e);
        chk({tag, ".err_count"},   longint'(err_count), e.err);
        chk({tag, ".sum_abs_err"}, longint'(sum_abs_err), e.abs_sum);
        chk({tag, ".sum_sgn_err"}, longint'($signed(sum_sgn_err)), e.sgn);
        chk({tag, ".max_abs_err"}, longint'(max_abs_err), e.mx);
        chk({tag, ".max_err_a"},   longint'(max_err_a), e.ma);
        chk({tag, ".max_err_b"},   longint'(max_err_b), e.mb);
    endtask

    task automatic q_clear();
        qa.delete(); qb.delete(); qc.delete(); qs.delete();
    endtask

    task automatic add_sample(input logic [W-1:0] sa, input logic [W-1:0] sb,
                              input logic sc, input logic [W:0] ss);
        qa.push_back(sa); qb.push_back(sb); qc.push_back(sc); qs.push_back(ss);
    endtask

    function automatic metrics_t model();
        metrics_t m = '{0, 0, 0, 0, 0, 0};
        for (int i = 0; i < qa.size(); i++) begin
            longint ex  = longint'(qa[i]) + longint'(qb[i]) + longint'(qc[i]);
            longint ed  = longint'(qs[i]) - ex;
            longint ae  = (ed < 0) ? -ed : ed;
            if (ae != 0) m.err++;
            m.abs_sum += ae;
            if (m.abs_sum > SAT_MAX) m.abs_sum = SAT_MAX;
            m.sgn += ed;
            if (ae > m.mx) begin
                m.mx = ae;
                m.ma = longint'(qa[i]);
                m.mb = longint'(qb[i]);
            end
        end
        return m;
    endfunction

    task automatic garbage();
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); s_approx = (W+1)'($urandom);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; n_samples = CW'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; n_samples = CW'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!done && c < 20) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            garbage();
            c++;
        end
        chk({tag, ".done_reached"}, longint'(done), 1);
        in_valid = 1'b0;
    endtask

    task automatic run_queued(input bit rnd, input metrics_t e, input string tag);
        int n = qa.size();
        int idx = 0;
        int guard = 0;
        metrics_t got;
        exp_q.push_back(e);
        do_start(n);
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (in_ready && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                a = qa[idx]; b = qb[idx]; cin = qc[idx]; s_approx = qs[idx];
                idx++;
            end else begin
                in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
                garbage();
            end
        end
        chk({tag, ".all_sent"}, longint'(idx), longint'(n));
        wait_done(tag);
        got = exp_q.pop_front();
        cmp_metrics(tag, got);
    endtask

    initial begin
        metrics_t e;
        rst_n = 1'b0; start = 1'b0; n_samples = '0; in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; s_approx = '0;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 9'h00A, '{1, 2,    2,    2,   8'h05, 8'h03}};
        tbl[1] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, '{0, 0,    0,    0,   0,     0    }};
        tbl[2] = '{8'h10, 8'h01, 1'b0, 9'h00F, '{1, 2,    -2,   2,   8'h10, 8'h01}};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 9'h1FF, '{1, 511,  511,  511, 0,     0    }};
        tbl[4] = '{8'hFF, 8'hFF, 1'b1, 9'h000, '{1, 511,  -511, 511, 8'hFF, 8'hFF}};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 9'h100, '{0, 0,    0,    0,   0,     0    }};
        tbl[6] = '{8'h7F, 8'h01, 1'b1, 9'h080, '{1, 1,    -1,   1,   8'h7F, 8'h01}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", longint'(in_ready), 0);
        chk("rst.busy", longint'(busy), 0);
        chk("rst.done", longint'(done), 0);
        cmp_metrics("rst", '{0, 0, 0, 0, 0, 0});
        rst_n = 1'b1;

        // Reset mid-run after 3 transfers
        do_start(10);
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0; s_approx = 9'h1FF;
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun.err_count", longint'(err_count), 3);
        chk("midrun.busy", longint'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", longint'(in_ready), 0);
        chk("midrst.busy", longint'(busy), 0);
        chk("midrst.done", longint'(done), 0);
        cmp_metrics("midrst", '{0, 0, 0, 0, 0, 0});
        @(negedge clk); rst_n = 1'b1;

        // Single sample with done latency of 2 cycles after transfer
        do_start(1);
        @(negedge clk);
        chk("lat.in_ready", longint'(in_ready), 1);
        in_valid = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0; s_approx = 9'h00A;
        @(negedge clk); in_valid = 1'b0;
        chk("lat.t0_done", longint'(done), 0);
        chk("lat.t0_in_ready", longint'(in_ready), 0);
        chk("lat.t0_busy", longint'(busy), 1);
        @(negedge clk);
        chk("lat.t1_done", longint'(done), 0);
        @(negedge clk);
        chk("lat.t2_done", longint'(done), 1);
        chk("lat.t2_busy", longint'(busy), 0);
        cmp_metrics("lat", '{1, 2, 2, 2, 8'h05, 8'h03});

        // Table-driven single-sample runs
        for (int i = 0; i < 7; i++) begin
            q_clear();
            add_sample(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s);
            run_queued(1'b0, tbl[i].exp_m, $sformatf("vec%0d", i));
        end

        // Three-sample mix
        q_clear();
        add_sample(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        add_sample(8'h10, 8'h01, 1'b0, 9'h00F);
        add_sample(8'h01, 8'h01, 1'b0, 9'h005);
        run_queued(1'b0, '{2, 5, 1, 3, 8'h01, 8'h01}, "mix3");

        // Ties keep first operands
        q_clear();
        add_sample(8'h01, 8'h02, 1'b0, 9'h007);
        add_sample(8'h03, 8'h03, 1'b0, 9'h002);
        run_queued(1'b1, '{2, 8, 0, 4, 8'h01, 8'h02}, "tie");

        // n_samples = 0 goes straight to DONE with cleared metrics
        do_start(0);
        chk("zero.done", longint'(done), 1);
        chk("zero.in_ready", longint'(in_ready), 0);
        chk("zero.busy", longint'(busy), 0);
        cmp_metrics("zero", '{0, 0, 0, 0, 0, 0});

        // start during RUN is ignored
        do_start(2);
        @(negedge clk);
        in_valid = 1'b1; a = 8'h05; b = 8'h03; cin = 1'b0; s_approx = 9'h00A;
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1; n_samples = CW'(5);
        @(negedge clk);
        start = 1'b0;
        chk("runstart.busy", longint'(busy), 1);
        chk("runstart.in_ready", longint'(in_ready), 1);
        in_valid = 1'b1; a = 8'h10; b = 8'h01; cin = 1'b0; s_approx = 9'h00F;
        wait_done("runstart");
        cmp_metrics("runstart", '{2, 4, 0, 2, 8'h05, 8'h03});

        // Max-error stream with random valid; narrow build saturates
        q_clear();
        for (int i = 0; i < 400; i++) begin
            if (i % 2 == 0) add_sample(8'h00, 8'h00, 1'b0, 9'h1FF);
            else            add_sample(8'hFF, 8'hFF, 1'b1, 9'h000);
        end
        run_queued(1'b1, model(), "maxed");
        chk("sat.sum_abs_err", longint'(sat_sum_abs_err), 1023);
        chk("sat.sum_sgn_err", longint'($signed(sat_sum_sgn_err)), 0);
        chk("sat.err_count", longint'(sat_err_count), 400);
        chk("sat.done", longint'(sat_done), 1);

        // Random sweep against the reference model
        q_clear();
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            logic [W:0]   ex, rs;
            int           k;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            ex = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            k  = $urandom_range(0, 2);
            if (k == 0)      rs = (W+1)'($urandom);
            else if (k == 1) rs = ex;
            else             rs = ex ^ ((W+1)'(1) << $urandom_range(0, W));
            add_sample(ra, rb, rc, rs);
        end
        run_queued(1'b1, model(), "sweep");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
